// File: rtl/tft_stream_monitor_pkg.sv
// Shared panel geometry defaults, FSM states and pixel payload types.
package tft_stream_monitor_pkg;

  localparam int unsigned TFT_H_ACTIVE = 480;
  localparam int unsigned TFT_V_ACTIVE = 272;
  localparam int unsigned TFT_VGAP_MIN = 1000;
  localparam int unsigned TFT_XW       = 9;
  localparam int unsigned TFT_YW       = 9;
  localparam int unsigned RGB_W        = 24;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One oversampled snapshot of the panel bus.
  typedef struct packed {
    logic clk;
    logic de;
    rgb_t rgb;
  } tft_sample_t;

endpackage

// File: rtl/tft_stream_monitor_if.sv
// DE-mode RGB panel bus between the driver (master) and the monitor (slave).
interface tft_stream_monitor_if;
  logic       tft_clk;
  logic       tft_de;
  logic [7:0] tft_r;
  logic [7:0] tft_g;
  logic [7:0] tft_b;

  modport master (output tft_clk, tft_de, tft_r, tft_g, tft_b);
  modport slave  (input  tft_clk, tft_de, tft_r, tft_g, tft_b);
endinterface

// File: rtl/tft_in_sync.sv
// Two-flop synchronizer for the panel bus plus tft_clk rising-edge detect.
module tft_in_sync
  import tft_stream_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tft_clk,
  input  logic tft_de,
  input  rgb_t tft_rgb,
  output logic tick_c,
  output logic de_s,
  output rgb_t rgb_s
);

  tft_sample_t sync1;
  tft_sample_t sync2;
  logic        clk_d;

  // Synchronizer chain; clk_d keeps the previous synchronized tft_clk level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      clk_d <= 1'b0;
    end else begin
      sync1 <= '{clk: tft_clk, de: tft_de, rgb: tft_rgb};
      sync2 <= sync1;
      clk_d <= sync2.clk;
    end
  end

  assign tick_c = sync2.clk & ~clk_d;
  assign de_s   = sync2.de;
  assign rgb_s  = sync2.rgb;

endmodule

// File: rtl/tft_stream_monitor.sv
// Rebuilds pixel coordinates from the oversampled panel stream, checks line and
// frame geometry, and captures one probe pixel per frame.
module tft_stream_monitor
  import tft_stream_monitor_pkg::*;
#(
  parameter int unsigned H_ACTIVE = TFT_H_ACTIVE,
  parameter int unsigned V_ACTIVE = TFT_V_ACTIVE,
  parameter int unsigned VGAP_MIN = TFT_VGAP_MIN,
  parameter int unsigned XW       = TFT_XW,
  parameter int unsigned YW       = TFT_YW
) (
  input  logic                 clk,
  input  logic                 reset_btn,
  tft_stream_monitor_if.slave  tft,
  input  logic [XW-1:0]        probe_x,
  input  logic [YW-1:0]        probe_y,
  input  logic                 err_clr,
  output logic                 pix_valid,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic [RGB_W-1:0]     pix_rgb,
  output logic                 frame_start,
  output logic                 locked,
  output logic [RGB_W-1:0]     probe_rgb,
  output logic                 probe_hit,
  output logic                 err_hlen,
  output logic                 err_vlen
);

  localparam int unsigned   GW       = $clog2(VGAP_MIN + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(VGAP_MIN);
  localparam logic [GW-1:0] GAP_PRE  = GW'(VGAP_MIN - 1);

  rgb_t          tft_rgb;
  logic          tick_c;
  logic          de_s;
  rgb_t          rgb_s;
  mon_state_e    state;
  mon_state_e    state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          gap_reach_c;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          pv_nxt;
  logic          fs_nxt;
  logic          hlen_set;
  logic          vlen_set;

  assign tft_rgb = '{r: tft.tft_r, g: tft.tft_g, b: tft.tft_b};

  tft_in_sync u_in_sync (
    .clk     (clk),
    .rst_n   (reset_btn),
    .tft_clk (tft.tft_clk),
    .tft_de  (tft.tft_de),
    .tft_rgb (tft_rgb),
    .tick_c  (tick_c),
    .de_s    (de_s),
    .rgb_s   (rgb_s)
  );

  // True on the DE-low tick that completes (or extends) a vertical gap.
  assign gap_reach_c = tick_c && !de_s && (gap_cnt >= GAP_PRE);

  // Consecutive DE-low tick counter, saturating at VGAP_MIN.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      gap_cnt <= '0;
    end else if (tick_c) begin
      if (de_s)                  gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) state <= SYNC;
    else            state <= state_nxt;
  end

  // Next state, next coordinates and error strobes; pix_x/pix_y double as counters.
  always_comb begin
    state_nxt = state;
    x_nxt     = pix_x;
    y_nxt     = pix_y;
    pv_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    hlen_set  = 1'b0;
    vlen_set  = 1'b0;
    if (tick_c) begin
      unique case (state)
        SYNC: begin
          if (gap_reach_c) state_nxt = VBLANK;
        end
        VBLANK: begin
          if (de_s) begin
            state_nxt = ACTIVE;
            x_nxt     = '0;
            y_nxt     = '0;
            pv_nxt    = 1'b1;
            fs_nxt    = 1'b1;
          end
        end
        ACTIVE: begin
          if (de_s) begin
            pv_nxt = 1'b1;
            if (pix_x == X_LAST) hlen_set = 1'b1;
            else                 x_nxt    = pix_x + XW'(1);
          end else begin
            state_nxt = HBLANK;
            hlen_set  = (pix_x != X_LAST);
          end
        end
        HBLANK: begin
          if (de_s) begin
            state_nxt = ACTIVE;
            x_nxt     = '0;
            pv_nxt    = 1'b1;
            if (pix_y == Y_LAST) vlen_set = 1'b1;
            else                 y_nxt    = pix_y + YW'(1);
          end else if (gap_reach_c) begin
            state_nxt = VBLANK;
            vlen_set  = (pix_y != Y_LAST);
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Registered pixel outputs; coordinates and colour hold between pixels.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      pix_valid   <= pv_nxt;
      frame_start <= fs_nxt;
      locked      <= (state_nxt != SYNC);
      if (pv_nxt) begin
        pix_x   <= x_nxt;
        pix_y   <= y_nxt;
        pix_rgb <= rgb_s;
      end
    end
  end

  // Sticky geometry errors; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      err_hlen <= 1'b0;
      err_vlen <= 1'b0;
    end else begin
      err_hlen <= hlen_set | (err_hlen & ~err_clr);
      err_vlen <= vlen_set | (err_vlen & ~err_clr);
    end
  end

  // Probe capture one cycle after the matching pixel is presented.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      probe_rgb <= '0;
      probe_hit <= 1'b0;
    end else if (pix_valid && (pix_x == probe_x) && (pix_y == probe_y)) begin
      probe_rgb <= pix_rgb;
      probe_hit <= 1'b1;
    end else begin
      probe_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tft_stream_monitor.sv
// Scoreboard bench for tft_stream_monitor on a scaled-down panel geometry.
module tb_tft_stream_monitor;
  import tft_stream_monitor_pkg::*;

  localparam int H  = 8;
  localparam int V  = 5;
  localparam int VG = 16;
  localparam int HB = 3;
  localparam int VB = 24;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 9;
  localparam logic [23:0] PROBE_VAL = 24'hA5C3E7;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [23:0]   rgb;
    logic          fs;
    int unsigned   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_btn;
  logic          err_clr;
  logic [XW-1:0] probe_x;
  logic [YW-1:0] probe_y;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [23:0]   pix_rgb;
  logic          frame_start;
  logic          locked;
  logic [23:0]   probe_rgb;
  logic          probe_hit;
  logic          err_hlen;
  logic          err_vlen;

  tft_stream_monitor_if tft_bus ();

  tft_stream_monitor #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .VGAP_MIN (VG),
    .XW       (XW),
    .YW       (YW)
  ) dut (
    .clk         (clk),
    .reset_btn   (reset_btn),
    .tft         (tft_bus),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .err_clr     (err_clr),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .probe_rgb   (probe_rgb),
    .probe_hit   (probe_hit),
    .err_hlen    (err_hlen),
    .err_vlen    (err_vlen)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb_q[$];
  logic [23:0] probe_q[$];
  logic [41:0] obs_log[$];
  logic [41:0] log_a[$];
  bit          log_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_probe_exp = 0;
  int          n_probe_seen = 0;
  int          div = 4;
  logic [23:0] pat [V][H];

  // Reference model: what the generator has sent since the last reset.
  bit          m_locked = 1'b0;
  int          m_gap = 0;
  bit          m_frame = 1'b0;
  int          m_lines = 0;
  bit          m_err_h = 1'b0;
  bit          m_err_v = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [95:0] outs_all();
    return 96'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                probe_rgb, probe_hit, err_hlen, err_vlen});
  endfunction

  // Output monitor: pops the scoreboard whenever the DUT presents a pixel or probe hit.
  always @(negedge clk) begin
    exp_t e;
    if (reset_btn === 1'b1) begin
      if (pix_valid) begin
        if (sb_q.size() == 0) begin
          bad("unexpected_pix_valid", int'(pix_x));
        end else begin
          e = sb_q.pop_front();
          chk("pix_x", 96'(pix_x), 96'(e.x));
          chk("pix_y", 96'(pix_y), 96'(e.y));
          chk("pix_rgb", 96'(pix_rgb), 96'(e.rgb));
          chk("frame_start", 96'(frame_start), 96'(e.fs));
          chk("pix_latency", 96'(cyc), 96'(e.cyc));
        end
        if (log_en) obs_log.push_back({pix_x, pix_y, pix_rgb});
      end else if (frame_start) begin
        bad("frame_start_without_pix", int'(pix_y));
      end
      if (probe_hit) begin
        n_probe_seen++;
        if (probe_q.size() == 0) bad("unexpected_probe_hit", int'(probe_rgb));
        else                     chk("probe_rgb", 96'(probe_rgb), 96'(probe_q.pop_front()));
      end
    end
  end

  // One tft_clk period; data changes with the rise and holds the whole period.
  task automatic tft_edge(input logic de, input logic [23:0] rgb, input bit emit,
                          input exp_t e, input bit clr_pulse);
    exp_t ex;
    ex = e;
    tft_bus.tft_de = de;
    {tft_bus.tft_r, tft_bus.tft_g, tft_bus.tft_b} = rgb;
    tft_bus.tft_clk = 1'b1;
    if (emit) begin
      ex.cyc = cyc + 3;
      sb_q.push_back(ex);
      if (ex.x == probe_x && ex.y == probe_y) begin
        probe_q.push_back(ex.rgb);
        n_probe_exp++;
      end
    end
    for (int k = 1; k <= div; k++) begin
      @(negedge clk);
      if (k == div / 2) tft_bus.tft_clk = 1'b0;
      if (clr_pulse && k == 2) err_clr = 1'b1;
      if (clr_pulse && k == 3) err_clr = 1'b0;
    end
  endtask

  // Blanking edge; optionally clears errors in the very cycle a vertical gap completes.
  task automatic send_low(input bit clr_req);
    exp_t e;
    bit   reach;
    e = '{x: '0, y: '0, rgb: '0, fs: 1'b0, cyc: 0};
    m_gap++;
    reach = (m_gap == VG);
    if (reach) begin
      if (m_frame && m_lines != V) m_err_v = 1'b1;
      m_frame  = 1'b0;
      m_locked = 1'b1;
      if (clr_req) m_err_h = 1'b0;
    end
    tft_edge(1'b0, 24'($urandom), 1'b0, e, clr_req && reach);
  endtask

  task automatic mid_reset();
    reset_btn = 1'b0;
    #1;
    chk("mid_reset_outputs_zero", outs_all(), 96'(0));
    m_locked = 1'b0;
    m_gap    = 0;
    m_frame  = 1'b0;
    m_err_h  = 1'b0;
    m_err_v  = 1'b0;
    @(negedge clk);
    reset_btn = 1'b1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err_h = 1'b0;
    m_err_v = 1'b0;
    @(negedge clk);
    chk("err_hlen_after_clr", 96'(err_hlen), 96'(m_err_h));
    chk("err_vlen_after_clr", 96'(err_vlen), 96'(m_err_v));
  endtask

  // One frame followed by its vertical gap; expectations come from the frame plan.
  task automatic send_frame(input int nlines, input int short_line, input int short_len,
                            input bit reuse, input int rst_line, input bit clr_on_vgap);
    exp_t        e;
    logic [23:0] px;
    int          len;
    int          gap;
    m_frame = m_locked;
    m_lines = nlines;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? short_len : H;
      for (int p = 0; p < len; p++) begin
        if (!reuse) pat[l][p] = 24'($urandom);
        px = (l == V - 1 && p == H - 1) ? PROBE_VAL : pat[l][p];
        e.x   = XW'(p);
        e.y   = YW'(l);
        e.rgb = px;
        e.fs  = (l == 0 && p == 0);
        e.cyc = 0;
        m_gap = 0;
        tft_edge(1'b1, px, m_locked, e, 1'b0);
        if (l == rst_line && p == 2) mid_reset();
      end
      if (m_locked && len != H) m_err_h = 1'b1;
      gap = (l == nlines - 1) ? VB : HB;
      for (int i = 0; i < gap; i++) begin
        send_low(clr_on_vgap);
        if (i == 0) chk("err_hlen_at_de_fall", 96'(err_hlen), 96'(m_err_h));
      end
    end
    chk("err_vlen_frame_end", 96'(err_vlen), 96'(m_err_v));
    chk("locked_frame_end", 96'(locked), 96'(m_locked));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_btn       = 1'b0;
    err_clr         = 1'b0;
    probe_x         = XW'(H - 1);
    probe_y         = YW'(V - 1);
    tft_bus.tft_clk = 1'b0;
    tft_bus.tft_de  = 1'b0;
    tft_bus.tft_r   = 8'h00;
    tft_bus.tft_g   = 8'h00;
    tft_bus.tft_b   = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_all(), 96'(0));
    reset_btn = 1'b1;
    @(negedge clk);

    // Initial vertical gap: lock on the VG-th DE-low edge, not before.
    for (int i = 0; i < VB; i++) begin
      send_low(1'b0);
      if (i == VG - 2) chk("locked_before_full_gap", 96'(locked), 96'(0));
    end
    chk("locked_after_gap", 96'(locked), 96'(1));

    // Clean frames with the probe pixel at the last position.
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);
    chk("probe_rgb_after_frames", 96'(probe_rgb), 96'(PROBE_VAL));

    // Short line, then clear.
    send_frame(V, 2, H - 1, 1'b0, -1, 1'b0);
    pulse_clr();

    // Short frame with err_clr landing on the same cycle as the error.
    send_frame(V - 1, -1, 0, 1'b0, -1, 1'b1);
    chk("err_vlen_set_beats_clr", 96'(err_vlen), 96'(1));
    pulse_clr();

    // Reset mid-line 2; relock after the next full gap.
    send_frame(V, -1, 0, 1'b0, 2, 1'b0);
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);

    // Same frame content at two pixel-clock ratios.
    div    = 4;
    log_en = 1'b1;
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);
    log_en = 1'b0;
    log_a  = obs_log;
    obs_log.delete();
    div    = 11;
    log_en = 1'b1;
    send_frame(V, -1, 0, 1'b1, -1, 1'b0);
    log_en = 1'b0;
    chk("seq_len_div4_vs_div11", 96'(obs_log.size()), 96'(log_a.size()));
    for (int i = 0; i < log_a.size() && i < obs_log.size(); i++)
      chk("seq_div4_vs_div11", 96'(obs_log[i]), 96'(log_a[i]));

    repeat (8) @(negedge clk);
    chk("probe_rgb_final", 96'(probe_rgb), 96'(PROBE_VAL));
    chk("scoreboard_drained", 96'(sb_q.size()), 96'(0));
    chk("probe_hit_count", 96'(n_probe_seen), 96'(n_probe_exp));
    chk("err_flags_final", 96'({err_hlen, err_vlen}), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
